vga_timing_pattern_gen: RTL
===========================

Name: vga_timing_pattern_gen

Overview:
- Parametrised raster timing generator and test-pattern source for the VGA output path.
- Generalises the fixed 1280x1024@60 sync generator:
  - H/V timing set by parameters.
  - Sync polarity and colour depth are parameters.
  - Outputs include data-enable, pixel coordinates and frame/line strobes.
  - Four selectable test patterns.
- Sits directly in front of the DAC/pin interface; clocked by the pixel clock.

Parameters:
- H_ACTIVE, 1280, visible pixels per line
- H_FP, 48, horizontal front porch (clocks)
- H_SYNC, 112, horizontal sync width
- H_BP, 248, horizontal back porch
- V_ACTIVE, 1024, visible lines per frame
- V_FP, 1, vertical front porch (lines)
- V_SYNC, 3, vertical sync width
- V_BP, 38, vertical back porch
- HSYNC_POL, 1, HSYNC level during sync pulse (1 = active-high)
- VSYNC_POL, 1, VSYNC level during sync pulse
- COLOR_W, 4, bits per colour channel
- CNT_W, 12, width of internal counters and X/Y ports

Ports:
- CLK  in  1  pixel clock
- RST_N  in  1  asynchronous active-low reset
- MODE  in  2  pattern select: 0 solid, 1 colour bars, 2 grid, 3 checkerboard
- SOLID  in  3*COLOR_W  {R,G,B} colour used in MODE 0
- HSYNC  out  1  horizontal sync
- VSYNC  out  1  vertical sync
- DE  out  1  active-video enable
- X  out  CNT_W  pixel column, valid when DE=1
- Y  out  CNT_W  pixel row, valid when DE=1
- FRAME_START  out  1  one-cycle pulse at pixel (0,0)
- LINE_START  out  1  one-cycle pulse at column 0 of every active line
- R, G, B  out  COLOR_W each  pixel colour

Behaviour:
- Clock and reset: one clock; reset is asynchronous and active-low.
- Derived constants: H_TOTAL = sum of H_*; V_TOTAL = sum of V_*.
- Counters:
  - hcnt counts 0..H_TOTAL-1 and wraps to 0.
  - vcnt increments on each hcnt wrap; vcnt wraps 0..V_TOTAL-1.
- Region order per line: active [0,H_ACTIVE), front porch, sync, back porch. Vertical uses the same order.
- Sync windows:
  - HSYNC = HSYNC_POL when H_ACTIVE+H_FP <= hcnt < H_ACTIVE+H_FP+H_SYNC, else ~HSYNC_POL.
  - VSYNC uses the same rule on vcnt with the V_* parameters. VSYNC changes only on hcnt wrap.
- Latency: all outputs are registered and mutually aligned, one clock after counter state. HSYNC, VSYNC, DE, X, Y, strobes and RGB always describe the same pixel.
- DE = 1 only when hcnt < H_ACTIVE and vcnt < V_ACTIVE. X = hcnt, Y = vcnt.
- FRAME_START = 1 when hcnt=0 and vcnt=0. LINE_START = 1 when hcnt=0 and vcnt < V_ACTIVE.
- MODE sampling: MODE is captured into a shadow register only when the counters are at (0,0). A pattern never changes mid-frame. SOLID is sampled live.
- Patterns (active video only):
  - 0: {R,G,B} = SOLID.
  - 1: eight bars, BAR_W = H_ACTIVE/8 (integer). Order: white, yellow, cyan, green, magenta, red, blue, black. The last bar absorbs the remainder columns. Full-scale is all-ones.
  - 2: grid. White where X[4:0]==0 or Y[4:0]==0, else black.
  - 3: checkerboard. White where X[5]^Y[5], else black.
- Blanking: R/G/B = 0 whenever DE = 0.
- Reset values:
  - hcnt = vcnt = 0; shadow mode = 0.
  - HSYNC = ~HSYNC_POL, VSYNC = ~VSYNC_POL.
  - DE = 0, X = Y = 0, strobes = 0, RGB = 0.
- After RST_N deasserts, the first output cycle shows pixel (0,0) with FRAME_START = 1, and the MODE value present at that edge is captured.
- Reset mid-frame: counters and outputs return to their reset values immediately (asynchronous). No partial-frame state is retained.

Optional Feature:
- Macro: VGA_CURSOR_EN.
- When defined:
  - Adds ports CUR_X in CNT_W and CUR_Y in CNT_W.
  - During active video, pixels with X==CUR_X or Y==CUR_Y output the bitwise inverse of the pattern colour (crosshair).
  - CUR_X/CUR_Y are sampled at frame start, like MODE.
  - Latency is unchanged.
- When undefined: ports are absent and output is identical to the base behaviour.

Test Plan:
1. Parameters H 16/2/3/3, V 8/1/2/1, POL=1, reset released:
   - H_TOTAL=24, V_TOTAL=12.
   - HSYNC high for 3 clocks starting at X-equivalent hcnt=18.
   - VSYNC high for 2 full lines starting at vcnt=9.
   - 288 clocks between FRAME_START pulses.
2. Same parameters, HSYNC_POL=0, VSYNC_POL=0 -> sync pulses low with identical timing; both idle high out of reset.
3. MODE=1, H_ACTIVE=16 -> BAR_W=2:
   - Columns 0-1 output R=G=B=4'hF.
   - Columns 2-3 output R=G=F, B=0.
   - Columns 14-15 output 0.
   - Every blanking pixel outputs 0.
4. MODE changed 0->2 at mid-frame (vcnt=3) -> the remainder of that frame stays SOLID; the grid appears from the next FRAME_START. Grid frame: (0,0) white; (1,1) black.
5. RST_N pulsed low at hcnt=10, vcnt=5:
   - Outputs go to reset values asynchronously, without waiting for a clock edge.
   - After release, the first output has FRAME_START=1, X=0, Y=0, DE=1.
6. VGA_CURSOR_EN defined, MODE=0, SOLID=12'h0F0, CUR_X=5, CUR_Y=3:
   - Pixels (5,*) and (*,3) output 12'hF0F.
   - All other active pixels output 12'h0F0.

Source files
------------

// File: rtl/vga_timing_pattern_gen.sv
// vga_timing_pattern_gen
// Parametrised raster timing generator with built-in test patterns.
// Optional crosshair cursor overlay is enabled by defining VGA_CURSOR_EN,
// which adds the CUR_X / CUR_Y ports. Without it the output is the plain pattern.
// All outputs are registered and describe the same pixel, one clock after
// the counter state that produced them.
module vga_timing_pattern_gen #(
    parameter int H_ACTIVE  = 1280,
    parameter int H_FP      = 48,
    parameter int H_SYNC    = 112,
    parameter int H_BP      = 248,
    parameter int V_ACTIVE  = 1024,
    parameter int V_FP      = 1,
    parameter int V_SYNC    = 3,
    parameter int V_BP      = 38,
    parameter int HSYNC_POL = 1,
    parameter int VSYNC_POL = 1,
    parameter int COLOR_W   = 4,
    parameter int CNT_W     = 12
) (
    input  logic                   CLK,
    input  logic                   RST_N,
    input  logic [1:0]             MODE,
    input  logic [3*COLOR_W-1:0]   SOLID,
`ifdef VGA_CURSOR_EN
    input  logic [CNT_W-1:0]       CUR_X,
    input  logic [CNT_W-1:0]       CUR_Y,
`endif
    output logic                   HSYNC,
    output logic                   VSYNC,
    output logic                   DE,
    output logic [CNT_W-1:0]       X,
    output logic [CNT_W-1:0]       Y,
    output logic                   FRAME_START,
    output logic                   LINE_START,
    output logic [COLOR_W-1:0]     R,
    output logic [COLOR_W-1:0]     G,
    output logic [COLOR_W-1:0]     B
);

    // ------------------------------------------------------------------
    // Derived timing constants
    // ------------------------------------------------------------------
    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int BAR_W   = H_ACTIVE / 8;
    localparam int PIX_W   = 3 * COLOR_W;

    localparam logic [CNT_W-1:0] H_ACT_C     = CNT_W'(H_ACTIVE);
    localparam logic [CNT_W-1:0] H_SYNC_BEG  = CNT_W'(H_ACTIVE + H_FP);
    localparam logic [CNT_W-1:0] H_SYNC_END  = CNT_W'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [CNT_W-1:0] H_LAST      = CNT_W'(H_TOTAL - 1);
    localparam logic [CNT_W-1:0] V_ACT_C     = CNT_W'(V_ACTIVE);
    localparam logic [CNT_W-1:0] V_SYNC_BEG  = CNT_W'(V_ACTIVE + V_FP);
    localparam logic [CNT_W-1:0] V_SYNC_END  = CNT_W'(V_ACTIVE + V_FP + V_SYNC);
    localparam logic [CNT_W-1:0] V_LAST      = CNT_W'(V_TOTAL - 1);

    localparam logic HS_ON = (HSYNC_POL != 0);
    localparam logic VS_ON = (VSYNC_POL != 0);

    localparam logic [PIX_W-1:0] WHITE = {PIX_W{1'b1}};
    localparam logic [PIX_W-1:0] BLACK = {PIX_W{1'b0}};

    // ------------------------------------------------------------------
    // Raster counters
    // ------------------------------------------------------------------
    logic [CNT_W-1:0] hcnt_reg, hcnt_next;
    logic [CNT_W-1:0] vcnt_reg, vcnt_next;
    logic             h_last;
    logic             v_last;

    assign h_last = (hcnt_reg == H_LAST);
    assign v_last = (vcnt_reg == V_LAST);

    // Next-count logic: hcnt wraps every line, vcnt steps on each hcnt wrap.
    always_comb begin
        hcnt_next = hcnt_reg + 1'b1;
        vcnt_next = vcnt_reg;
        if (h_last) begin
            hcnt_next = '0;
            vcnt_next = v_last ? '0 : (vcnt_reg + 1'b1);
        end
    end

    // Counter state registers.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            hcnt_reg <= '0;
            vcnt_reg <= '0;
        end else begin
            hcnt_reg <= hcnt_next;
            vcnt_reg <= vcnt_next;
        end
    end

    // ------------------------------------------------------------------
    // Region decode for the pixel currently addressed by the counters
    // ------------------------------------------------------------------
    logic h_active, v_active, h_sync, v_sync, active, at_origin;

    assign h_active  = (hcnt_reg < H_ACT_C);
    assign v_active  = (vcnt_reg < V_ACT_C);
    assign h_sync    = (hcnt_reg >= H_SYNC_BEG) && (hcnt_reg < H_SYNC_END);
    assign v_sync    = (vcnt_reg >= V_SYNC_BEG) && (vcnt_reg < V_SYNC_END);
    assign active    = h_active && v_active;
    assign at_origin = (hcnt_reg == '0) && (vcnt_reg == '0);

    // ------------------------------------------------------------------
    // Frame-stable controls. At the origin pixel the live input is used so
    // the new value already applies to pixel (0,0); elsewhere the shadow
    // copy taken at the origin keeps the whole frame consistent.
    // ------------------------------------------------------------------
    logic [1:0] mode_reg;
    logic [1:0] mode_eff;

    assign mode_eff = at_origin ? MODE : mode_reg;

`ifdef VGA_CURSOR_EN
    logic [CNT_W-1:0] cur_x_reg, cur_y_reg;
    logic [CNT_W-1:0] cur_x_eff, cur_y_eff;

    assign cur_x_eff = at_origin ? CUR_X : cur_x_reg;
    assign cur_y_eff = at_origin ? CUR_Y : cur_y_reg;

    // Cursor position shadow, refreshed only at the start of a frame.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            cur_x_reg <= '0;
            cur_y_reg <= '0;
        end else if (at_origin) begin
            cur_x_reg <= CUR_X;
            cur_y_reg <= CUR_Y;
        end
    end
`endif

    // Pattern-select shadow, refreshed only at the start of a frame.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            mode_reg <= 2'd0;
        end else if (at_origin) begin
            mode_reg <= MODE;
        end
    end

    // ------------------------------------------------------------------
    // Colour bars: the bar index is the number of bar edges already passed.
    // Edges sit at multiples of BAR_W; anything past the seventh edge falls
    // into the last (black) bar, which absorbs the remainder columns.
    // ------------------------------------------------------------------
    logic [6:0] bar_ge;
    logic [2:0] bar_idx;

    genvar gi;
    generate
        for (gi = 0; gi < 7; gi++) begin : g_bar_edge
            localparam logic [CNT_W-1:0] EDGE = CNT_W'((gi + 1) * BAR_W);
            assign bar_ge[gi] = (hcnt_reg >= EDGE);
        end
    endgenerate

    // Count the passed bar edges to form the bar index.
    always_comb begin
        bar_idx = 3'd0;
        for (int i = 0; i < 7; i++) begin
            bar_idx = bar_idx + {2'b00, bar_ge[i]};
        end
    end

    // Bar order white, yellow, cyan, green, magenta, red, blue, black maps
    // neatly onto the inverted index bits: R=~idx[1], G=~idx[2], B=~idx[0].
    logic [PIX_W-1:0] bar_pix;
    assign bar_pix = {{COLOR_W{~bar_idx[1]}},
                      {COLOR_W{~bar_idx[2]}},
                      {COLOR_W{~bar_idx[0]}}};

    // ------------------------------------------------------------------
    // Pattern selection, cursor overlay and blanking
    // ------------------------------------------------------------------
    logic [PIX_W-1:0] pat_pix;
    logic [PIX_W-1:0] ovl_pix;
    logic [PIX_W-1:0] rgb_next;

    // Select the test pattern colour for the addressed pixel.
    always_comb begin
        pat_pix = BLACK;
        case (mode_eff)
            2'd0: pat_pix = SOLID;
            2'd1: pat_pix = bar_pix;
            2'd2: pat_pix = ((hcnt_reg[4:0] == 5'd0) || (vcnt_reg[4:0] == 5'd0))
                            ? WHITE : BLACK;
            default: pat_pix = (hcnt_reg[5] ^ vcnt_reg[5]) ? WHITE : BLACK;
        endcase
    end

`ifdef VGA_CURSOR_EN
    // Crosshair: invert the pattern on the cursor row and column.
    always_comb begin
        ovl_pix = pat_pix;
        if ((hcnt_reg == cur_x_eff) || (vcnt_reg == cur_y_eff)) begin
            ovl_pix = ~pat_pix;
        end
    end
`else
    // No overlay in this build: pattern passes straight through.
    always_comb begin
        ovl_pix = pat_pix;
    end
`endif

    assign rgb_next = active ? ovl_pix : BLACK;

    // ------------------------------------------------------------------
    // Output registers: everything sampled from the same counter state
    // ------------------------------------------------------------------
    logic                 hsync_reg, vsync_reg, de_reg;
    logic                 frame_start_reg, line_start_reg;
    logic [CNT_W-1:0]     x_reg, y_reg;
    logic [PIX_W-1:0]     rgb_reg;

    // Register sync, enable, coordinates, strobes and colour together.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            hsync_reg       <= ~HS_ON;
            vsync_reg       <= ~VS_ON;
            de_reg          <= 1'b0;
            x_reg           <= '0;
            y_reg           <= '0;
            frame_start_reg <= 1'b0;
            line_start_reg  <= 1'b0;
            rgb_reg         <= '0;
        end else begin
            hsync_reg       <= h_sync ? HS_ON : ~HS_ON;
            vsync_reg       <= v_sync ? VS_ON : ~VS_ON;
            de_reg          <= active;
            x_reg           <= hcnt_reg;
            y_reg           <= vcnt_reg;
            frame_start_reg <= at_origin;
            line_start_reg  <= (hcnt_reg == '0) && v_active;
            rgb_reg         <= rgb_next;
        end
    end

    assign HSYNC       = hsync_reg;
    assign VSYNC       = vsync_reg;
    assign DE          = de_reg;
    assign X           = x_reg;
    assign Y           = y_reg;
    assign FRAME_START = frame_start_reg;
    assign LINE_START  = line_start_reg;
    assign R           = rgb_reg[3*COLOR_W-1:2*COLOR_W];
    assign G           = rgb_reg[2*COLOR_W-1:COLOR_W];
    assign B           = rgb_reg[COLOR_W-1:0];

endmodule
